// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single memory port between the instruction-fetch (I) side and the
// data-access (D) side of the core. One requester is picked in IDLE, its
// request is latched onto the memory bus, and the read data is returned with
// a one-cycle active-low ack. A memory that never answers is cut off after
// TIMEOUT busy cycles: the requester still gets its ack (with zero data) and
// bus_err pulses so the hang is visible.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   i_req/i_addr        fetch request (always a word read)
//   i_rdata/i_ack_n     fetch data and one-cycle active-low completion
//   d_req/d_we/d_size   data request, store flag, access size
//   d_addr/d_wdata      data address and store data
//   d_rdata/d_ack_n     data read data and one-cycle active-low completion
//   m_req/m_we/m_size   memory request, write enable, access size
//   m_addr/m_wdata      memory address and write data
//   m_rdata/m_ack_n     memory read data and active-low completion
//   bus_err             one-cycle pulse when a hung transaction is aborted
//
// State    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | memory bus free; arbitrate between i_req and d_req each cycle
// I_BUSY   | fetch on the memory bus, waiting for m_ack_n or timeout
// D_BUSY   | data access on the memory bus, waiting for m_ack_n or timeout
// RESP     | requester ack_n low for this single cycle
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int D_STREAK = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack_n,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack_n,

  output logic          m_req,
  output logic          m_we,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack_n,

  output logic          bus_err
);

  localparam int SW = $clog2(D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q,   state_d;
  logic [SW-1:0] streak_q,  streak_d;
  logic [TW-1:0] tmo_q,     tmo_d;
  logic [TW-1:0] tmo_inc;

  logic          m_req_q,   m_req_d;
  logic          m_we_q,    m_we_d;
  logic [1:0]    m_size_q,  m_size_d;
  logic [AW-1:0] m_addr_q,  m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;

  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_n_q, i_ack_n_d;
  logic          d_ack_n_q, d_ack_n_d;
  logic          bus_err_q, bus_err_d;

  // D wins ties until it has taken D_STREAK grants in a row while I was
  // waiting; then I gets the next grant so fetch cannot be starved.
  logic          d_wins;
  assign d_wins  = d_req && !(i_req && (streak_q == STREAK_MAX));
  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    tmo_d     = tmo_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_n_d = 1'b1;
    d_ack_n_d = 1'b1;
    bus_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (d_wins) begin
          state_d   = D_BUSY;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (i_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (i_req) begin
          state_d  = I_BUSY;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_size_d = 2'b00;
          m_addr_d = i_addr;
          streak_d = '0;
        end
      end

      I_BUSY, D_BUSY: begin
        tmo_d = tmo_inc;
        if (!m_ack_n) begin
          m_req_d = 1'b0;
          state_d = RESP;
          if (state_q == I_BUSY) begin
            i_rdata_d = m_rdata;
            i_ack_n_d = 1'b0;
          end else begin
            d_rdata_d = m_rdata;
            d_ack_n_d = 1'b0;
          end
        end else if (tmo_inc == TMO_LIMIT) begin
          // Memory never answered: release the bus and complete the
          // requester with zero data so the core does not hang with it.
          m_req_d   = 1'b0;
          state_d   = RESP;
          bus_err_d = 1'b1;
          if (state_q == I_BUSY) begin
            i_rdata_d = '0;
            i_ack_n_d = 1'b0;
          end else begin
            d_rdata_d = '0;
            d_ack_n_d = 1'b0;
          end
        end
      end

      RESP: begin
        // ack_n is low during this cycle only; requests are re-sampled in IDLE.
        tmo_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      tmo_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_n_q <= 1'b1;
      d_ack_n_q <= 1'b1;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      tmo_q     <= tmo_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_n_q <= i_ack_n_d;
      d_ack_n_q <= d_ack_n_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack_n = i_ack_n_q;
  assign d_ack_n = d_ack_n_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. A small memory model answers m_req
// after a programmable number of cycles (0 = never answers). Expected read
// data is pushed to a per-requester queue when a request is driven and
// popped when that requester's ack_n is seen low.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int D_STREAK = 4;
  localparam int TIMEOUT  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack_n;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_size = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack_n;
  logic          m_req;
  logic          m_we;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = 32'hDEAD_BEEF;
  logic          m_ack_n = 1'b1;
  logic          bus_err;

  mem_bus_arbiter #(
    .AW(AW), .DW(DW), .D_STREAK(D_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ack_n(i_ack_n),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_size (d_size),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack_n(d_ack_n),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_size (m_size),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack_n(m_ack_n),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  string         ack_log = "";
  int            bus_err_cnt = 0;

  int            mem_lat  = 1;
  bit            late_ack = 1'b0;
  int            mem_cnt  = 0;
  logic [AW-1:0] held_addr;
  logic [34:0]   held_attr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_0010) return 32'h2402_0005;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (mem_lat == 0) ? '0 : mem_fn(a);
  endfunction

  // Memory model: answers in the mem_lat-th cycle of m_req; drives junk data
  // outside the ack cycle so a mistimed capture shows up.
  always @(negedge clk) begin
    if (m_req === 1'b1) begin
      mem_cnt++;
      if (mem_cnt == 1) begin
        held_addr = m_addr;
        held_attr = {m_we, m_size, m_wdata};
      end else begin
        check("m_addr_stable", m_addr, held_addr);
        check("m_attr_stable", {m_we, m_size, m_wdata}, held_attr);
      end
      check("m_bus_matches_requester",
            ((i_req === 1'b1) && (m_addr === i_addr) && (m_we === 1'b0) && (m_size === 2'b00)) ||
            ((d_req === 1'b1) && (m_addr === d_addr) && (m_we === d_we) &&
             (m_size === d_size) && (m_wdata === d_wdata)), 1);
      if (mem_lat != 0 && mem_cnt == mem_lat) begin
        m_ack_n = 1'b0;
        m_rdata = mem_fn(m_addr);
      end else begin
        m_ack_n = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
      end
    end else begin
      mem_cnt = 0;
      m_ack_n = late_ack ? 1'b0 : 1'b1;
      m_rdata = late_ack ? 32'h1234_5678 : 32'hDEAD_BEEF;
    end
  end

  // Ack monitor: scoreboard pops, pulse width, exclusivity, bus_err count.
  bit prev_i_low = 1'b0;
  bit prev_d_low = 1'b0;
  always @(negedge clk) begin
    if (i_ack_n === 1'b0 || d_ack_n === 1'b0)
      check("ack_exclusive", i_ack_n | d_ack_n, 1);
    if (i_ack_n === 1'b0) begin
      check("i_ack_expected", i_exp_q.size() != 0, 1);
      if (i_exp_q.size() != 0) check("i_rdata", i_rdata, i_exp_q.pop_front());
      check("i_ack_width", prev_i_low, 0);
      ack_log = {ack_log, "I"};
    end
    if (d_ack_n === 1'b0) begin
      check("d_ack_expected", d_exp_q.size() != 0, 1);
      if (d_exp_q.size() != 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
      check("d_ack_width", prev_d_low, 0);
      ack_log = {ack_log, "D"};
    end
    if (bus_err === 1'b1) bus_err_cnt++;
    prev_i_low = (i_ack_n === 1'b0);
    prev_d_low = (d_ack_n === 1'b0);
  end

  // Keeps up to n_i fetches and n_d data accesses outstanding back to back;
  // each requester moves to the next word after its ack.
  task automatic drive_traffic(input int n_i, input int n_d,
                               input logic [AW-1:0] i_base, input logic [AW-1:0] d_base,
                               input int budget);
    int i_left = n_i;
    int d_left = n_d;
    int i_k = 0;
    int d_k = 0;
    int cyc = 0;
    bit ia, da;
    @(posedge clk); #1;
    if (i_left > 0) begin
      i_addr = i_base; i_req = 1'b1; i_exp_q.push_back(exp_rd(i_addr));
    end
    if (d_left > 0) begin
      d_addr = d_base; d_req = 1'b1; d_exp_q.push_back(exp_rd(d_addr));
    end
    while ((i_left > 0 || d_left > 0) && cyc < budget) begin
      @(negedge clk);
      ia = (i_ack_n === 1'b0);
      da = (d_ack_n === 1'b0);
      @(posedge clk); #1;
      cyc++;
      if (ia && i_left > 0) begin
        i_left--; i_k++;
        if (i_left > 0) begin
          i_addr = i_base + AW'(4 * i_k); i_exp_q.push_back(exp_rd(i_addr));
        end else i_req = 1'b0;
      end
      if (da && d_left > 0) begin
        d_left--; d_k++;
        if (d_left > 0) begin
          d_addr = d_base + AW'(4 * d_k); d_exp_q.push_back(exp_rd(d_addr));
        end else d_req = 1'b0;
      end
    end
    check("traffic_complete", (i_left == 0) && (d_left == 0), 1);
    check("i_queue_drained", i_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy;
    bit  seen;

    // Reset: outputs at reset values, requests ignored while rst is low.
    i_req = 1'b1; i_addr = 32'h0000_0044;
    repeat (3) @(negedge clk);
    check("rst_m_req",   m_req,   0);
    check("rst_m_we",    m_we,    0);
    check("rst_m_size",  m_size,  0);
    check("rst_m_addr",  m_addr,  0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_i_ack_n", i_ack_n, 1);
    check("rst_d_ack_n", d_ack_n, 1);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_bus_err", bus_err, 0);
    i_req = 1'b0;
    #2 rst = 1'b1;

    // 1: lone fetch, memory answers immediately.
    mem_lat = 1;
    @(posedge clk); #1;
    i_addr = 32'h0000_0010; i_req = 1'b1; i_exp_q.push_back(32'h2402_0005);
    @(negedge clk);
    check("t1_m_req_cycle_n", m_req, 0);
    @(negedge clk);
    check("t1_m_req_cycle_n1", m_req, 1);
    check("t1_m_addr", m_addr, 32'h0000_0010);
    check("t1_i_ack_n_cycle_n1", i_ack_n, 1);
    @(negedge clk);
    check("t1_i_ack_n_cycle_n2", i_ack_n, 0);
    check("t1_i_rdata", i_rdata, 32'h2402_0005);
    check("t1_m_req_dropped", m_req, 0);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    check("t1_i_ack_n_released", i_ack_n, 1);

    // 2: both sides requesting continuously; D takes D_STREAK grants, then I.
    ack_log = "";
    drive_traffic(2, 8, 32'h0000_0100, 32'h0800_0000, 200);
    n_tests++;
    assert (ack_log == "DDDDIDDDDI") else begin
      n_fail++;
      $error("FAIL t2_grant_order: observed %s expected DDDDIDDDDI", ack_log);
    end

    // 3: byte store passed through unchanged.
    d_we = 1'b1; d_size = 2'b10; d_wdata = 32'h0000_0041;
    ack_log = "";
    drive_traffic(0, 1, '0, 32'hF000_0000, 20);
    n_tests++;
    assert (ack_log == "D") else begin
      n_fail++;
      $error("FAIL t3_single_ack: observed %s expected D", ack_log);
    end
    d_we = 1'b0; d_size = 2'b00; d_wdata = '0;

    // 4: memory never answers -> abort after TIMEOUT busy cycles.
    mem_lat = 0;
    @(posedge clk); #1;
    d_addr = 32'h0000_2000; d_req = 1'b1; d_exp_q.push_back('0);
    busy = 0; seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (d_ack_n === 1'b0) begin
        seen = 1'b1;
        check("t4_bus_err_with_ack", bus_err, 1);
        check("t4_d_rdata_zero", d_rdata, 0);
      end else if (m_req === 1'b1) begin
        busy++;
      end
    end
    check("t4_acked", seen, 1);
    check("t4_busy_cycles", busy, TIMEOUT);
    @(posedge clk); #1;
    d_req = 1'b0; late_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_late_m_req", m_req, 0);
      check("t4_late_d_ack_n", d_ack_n, 1);
      check("t4_late_i_ack_n", i_ack_n, 1);
      check("t4_late_bus_err", bus_err, 0);
    end
    @(posedge clk); #1;
    late_ack = 1'b0; mem_lat = 1;
    drive_traffic(1, 0, 32'h0000_0300, '0, 20);

    // 5: reset while D_BUSY drops m_req at once; no ack is ever produced.
    mem_lat = 0;
    @(posedge clk); #1;
    d_addr = 32'h0000_4000; d_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_req === 1'b1) seen = 1'b1;
    end
    check("t5_busy_reached", seen, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_m_req_async", m_req, 0);
    check("t5_d_ack_n_async", d_ack_n, 1);
    d_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5_m_req_in_reset", m_req, 0);
      check("t5_d_ack_n_in_reset", d_ack_n, 1);
    end
    #2 rst = 1'b1;
    mem_lat = 1;
    drive_traffic(0, 1, 32'h0000_5000, 32'h0000_5000, 20);

    // 6: slow memory (3 cycles), alternating and overlapping requests.
    mem_lat = 3;
    ack_log = "";
    drive_traffic(1, 0, 32'h0000_0600, '0, 30);
    drive_traffic(0, 1, '0, 32'h0000_0700, 30);
    drive_traffic(1, 0, 32'h0000_0604, '0, 30);
    d_we = 1'b1; d_size = 2'b01; d_wdata = 32'hCAFE_0123;
    drive_traffic(0, 1, '0, 32'h0000_0704, 30);
    d_we = 1'b0; d_size = 2'b00; d_wdata = '0;
    drive_traffic(1, 1, 32'h0000_0800, 32'h0000_0900, 40);
    n_tests++;
    assert (ack_log == "IDIDDI") else begin
      n_fail++;
      $error("FAIL t6_ack_sequence: observed %s expected IDIDDI", ack_log);
    end

    repeat (3) @(negedge clk);
    check("bus_err_pulse_count", bus_err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
